// File: rtl/row_max_ctrl_pkg.sv
// rtl/row_max_ctrl_pkg.sv - shared state type and default widths for the row-max controller
package row_max_ctrl_pkg;

  localparam int D_W_DEF     = 32;
  localparam int ROW_LEN_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } row_max_state_t;

endpackage

// File: rtl/row_max_ctrl_if.sv
// rtl/row_max_ctrl_if.sv - score-in / result-out handshake bundle for row_max_ctrl
interface row_max_ctrl_if #(
  parameter int D_W   = 32,
  parameter int IDX_W = 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [D_W-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [D_W-1:0]   out_max;
  logic        [IDX_W-1:0] out_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_idx
  );
endinterface

// File: rtl/row_max_ctrl_max.sv
// rtl/row_max_ctrl_max.sv - running signed maximum; no enable, so the caller feeds back the result to hold
module max
  import row_max_ctrl_pkg::*;
#(
  parameter int D_W = D_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  initialize,
  input  logic signed [D_W-1:0] data_i,
  output logic signed [D_W-1:0] max_o
);

  logic signed [D_W-1:0] max_q, max_d;

  // >= lets an equal later element replace the stored value
  always_comb begin
    max_d = max_q;
    if (initialize || (data_i >= max_q)) max_d = data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) max_q <= '0;
    else     max_q <= max_d;
  end

  assign max_o = max_q;

endmodule

// File: rtl/row_max_ctrl.sv
// rtl/row_max_ctrl.sv - sequences one score row through the max unit and tracks the argmax index
module row_max_ctrl
  import row_max_ctrl_pkg::*;
#(
  parameter int D_W     = D_W_DEF,
  parameter int ROW_LEN = ROW_LEN_DEF,
  parameter int IDX_W   = $clog2(ROW_LEN)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  row_max_ctrl_if.slave  bus,
  output logic           busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROW_LEN - 1);

  row_max_state_t        state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  accept;
  logic                  in_ready_c, out_valid_c, busy_c;
  logic                  initialize;
  logic signed [D_W-1:0] dp_in;
  logic signed [D_W-1:0] max_val;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        busy_c     = 1'b1;
        in_ready_c = 1'b1;
        accept     = bus.in_valid;
        if (accept) begin
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + 1'b1;
          if ((cnt_q == '0) || (bus.in_data >= max_val)) idx_d = cnt_q;
        end
      end
      DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Non-accept cycles recirculate the stored max so the unit holds its result
  assign initialize = accept && (cnt_q == '0);
  assign dp_in      = accept ? bus.in_data : max_val;

  max #(.D_W(D_W)) u_max (
    .clk        (clk),
    .rst        (rst),
    .initialize (initialize),
    .data_i     (dp_in),
    .max_o      (max_val)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_max   = max_val;
  assign bus.out_idx   = idx_q;
  assign busy          = busy_c;

endmodule

// File: tb/tb_row_max_ctrl.sv
// tb/tb_row_max_ctrl.sv - directed self-checking bench for row_max_ctrl with a row-level reference model
module tb_row_max_ctrl;

  localparam int D_W     = 32;
  localparam int ROW_LEN = 4;
  localparam int IDX_W   = 2;

  logic clk;
  logic rst;
  logic start;
  logic busy;

  int vectors;
  int miscompares;
  int hs_count;
  int exp_hs;

  logic signed [D_W-1:0] cur_row [ROW_LEN];
  longint                exp_max;
  longint                exp_idx;

  row_max_ctrl_if #(.D_W(D_W), .IDX_W(IDX_W)) bus ();

  row_max_ctrl #(.D_W(D_W), .ROW_LEN(ROW_LEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1) begin
      chk("cmp_max", longint'($signed(bus.out_max)), exp_max);
      chk("cmp_idx", longint'(bus.out_idx), exp_idx);
      chk("cmp_in_ready_done", longint'(bus.in_ready), 0);
      chk("cmp_busy_done", longint'(busy), 1);
      if (bus.out_ready) hs_count++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: row maximum with the later element winning ties
  task automatic set_row(input logic signed [D_W-1:0] a, b, c, d);
    longint m;
    cur_row[0] = a; cur_row[1] = b; cur_row[2] = c; cur_row[3] = d;
    m       = longint'(cur_row[0]);
    exp_idx = 0;
    for (int k = 1; k < ROW_LEN; k++) begin
      if (longint'(cur_row[k]) >= m) begin
        m       = longint'(cur_row[k]);
        exp_idx = k;
      end
    end
    exp_max = m;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_elem(input logic signed [D_W-1:0] d, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 100;
      step();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 0, 1);
    else         step();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic send_row(input int gap);
    do_start();
    for (int k = 0; k < ROW_LEN; k++) send_elem(cur_row[k], gap);
  endtask

  task automatic chk_result(input string name, input longint m, input longint i);
    chk({name, "_valid"}, longint'(bus.out_valid), 1);
    chk({name, "_max"}, longint'($signed(bus.out_max)), m);
    chk({name, "_idx"}, longint'(bus.out_idx), i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0; hs_count = 0; exp_hs = 0;
    exp_max = 0; exp_idx = 0;
    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_in_ready", longint'(bus.in_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_max", longint'($signed(bus.out_max)), 0);
    chk("rst_out_idx", longint'(bus.out_idx), 0);
    rst = 1'b0;
    step();

    set_row(3, -7, 12, 5);
    send_row(0); exp_hs++;
    chk_result("t1", 12, 2);
    step();
    chk("t1_idle_busy", longint'(busy), 0);
    chk("t1_idle_valid", longint'(bus.out_valid), 0);

    set_row(-5, -2, -9, -2);
    send_row(0); exp_hs++;
    chk_result("t2", -2, 3);
    step();

    set_row(1, 4, 2, 0);
    send_row(3); exp_hs++;
    chk_result("t3", 4, 1);
    step();

    bus.out_ready = 1'b0;
    set_row(10, 20, 30, -1);
    send_row(0); exp_hs++;
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      step();
      chk_result("t4_stall", 30, 2);
    end
    bus.out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("t4_start_ignored", longint'(busy), 0);
    step();
    chk("t4_idle_busy", longint'(busy), 0);
    chk("t4_idle_hold_max", longint'($signed(bus.out_max)), 30);
    chk("t4_idle_hold_idx", longint'(bus.out_idx), 2);

    set_row(1, 2, 3, 4);
    do_start();
    send_elem(cur_row[0], 0);
    send_elem(cur_row[1], 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid", longint'(bus.out_valid), 0);
    chk("t5_busy", longint'(busy), 0);
    chk("t5_in_ready", longint'(bus.in_ready), 0);
    chk("t5_max", longint'($signed(bus.out_max)), 0);
    chk("t5_idx", longint'(bus.out_idx), 0);
    step();
    set_row(8, 8, 1, 2);
    send_row(0); exp_hs++;
    chk_result("t5b", 8, 1);
    step();

    set_row(32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000);
    send_row(0); exp_hs++;
    chk_result("t6a", -64'sd2147483648, 3);
    step();
    set_row(0, -5, -6, -7);
    send_row(0); exp_hs++;
    chk_result("t6b", 0, 0);
    step();

    set_row(100, 50, 60, 70);
    send_row(0); exp_hs++;
    chk_result("t7a", 100, 0);
    step();
    set_row(-3, -4, -5, -6);
    send_row(0); exp_hs++;
    chk_result("t7b", -3, 0);
    step();
    step();

    chk("handshakes", longint'(hs_count), longint'(exp_hs));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
